hit_sample_fifo: RTL and testbench
==================================

// Module: hit_sample_fifo
// PURPOSE
//  Downstream of rast_magma's R18 sample outputs. Captures up to NUM_SAMPLES hit samples per cycle
//  (hit_R18S/color_R18U/hit_valid_R18H) and stores them in a circular FIFO. Drains them one sample
//  per cycle on a valid/ready stream to the shader/framebuffer stage. Reports fill level upstream
//  for throttling and flags dropped samples.
// PARAMETERS
//  SIGFIG       24  bits per coordinate/color word (= rast_params::SIGFIG)
//  AXIS          3  coordinates per sample (x,y,z)
//  COLORS        3  color channels per sample
//  NUM_SAMPLES   2  input lanes per cycle; 1 <= NUM_SAMPLES <= DEPTH
//  DEPTH        16  FIFO entries; power of two
//  AFULL_MARGIN  4  almostFull_RnnnnH asserts when free entries <= AFULL_MARGIN
// PORTS
//  clk               in   1                       clock
//  rst               in   1                       synchronous reset, active-high
//  hit_R18S          in   [NUM_SAMPLES][AXIS][SIGFIG] signed sample positions
//  color_R18U        in   [COLORS][SIGFIG]        unsigned color, shared by all lanes in the cycle
//  hit_valid_R18H    in   [NUM_SAMPLES]           per-lane hit strobe
//  hit_R19S          out  [AXIS][SIGFIG]          head sample position
//  color_R19U        out  [COLORS][SIGFIG]        head sample color
//  hitValid_R19H     out  1                       head entry valid
//  hitReady_R19H     in   1                       consumer accepts head this cycle
//  count_RnnnnU      out  $clog2(DEPTH+1)         current occupancy
//  almostFull_RnnnnH out  1                       occupancy >= DEPTH-AFULL_MARGIN
//  overflow_RnnnnH   out  1                       sticky: at least one valid sample dropped
// BEHAVIOUR
//  - Reset (rst=1 at posedge): rd/wr pointers=0, count=0, overflow=0. Outputs: hitValid=0, count=0,
//    almostFull=0, overflow=0. hit_R19S/color_R19U=0 (all data outputs forced 0 while hitValid=0).
//  - Reset overrides all same-cycle push/pop; input hits during a reset cycle are discarded
//    without setting overflow.
//  - Push: nPush = popcount(hit_valid_R18H). Valid lanes are written in ascending lane index to
//    consecutive slots starting at wr_ptr. Each entry stores {hit_R18S[lane], color_R18U}.
//    Invalid lanes consume no slot.
//  - Pop: pop = hitValid_R19H & hitReady_R19H. Advance rd_ptr by 1.
//  - Space for push = DEPTH - count + pop: a same-cycle pop frees its slot for that cycle's push.
//  - Overflow: if nPush > space, accept the lowest-indexed valid lanes that fit and drop the rest.
//    Set overflow_RnnnnH=1 next cycle; it stays set until rst.
//  - count_next = count + accepted - pop. Pointers are log2(DEPTH) bits, wrap modulo DEPTH.
//  - Output is show-ahead: hitValid_R19H = (count != 0). hit_R19S/color_R19U = mem[rd_ptr].
//    These are stable while hitValid=1 and hitReady=0.
//  - Latency: a sample pushed at edge N into an empty FIFO is presented on the outputs after
//    edge N (1 cycle). No combinational path from hit_valid_R18H to hitValid_R19H.
//  - No combinational path from hitReady_R19H to any output except through registered state.
//  - Ordering: strict FIFO; across cycles by time, within a cycle by lane index.
//  - almostFull_RnnnnH and count_RnnnnU are registered, derived from count after the update.
//  - Pop when empty is impossible: hitValid=0 gates pop.
// TESTING
//  1 Reset then idle: rst 2 cycles -> hitValid=0, count=0, overflow=0, data outs=0.
//  2 Single push, ready=1: lane1 only valid, hit=(5,7,9), color=(1,2,3) -> next cycle hitValid=1
//    with (5,7,9)/(1,2,3); count returns to 0 the cycle after.
//  3 Ordering, ready=0: cycle A lanes{0,1}=(1,1,1),(2,2,2); cycle B lane0=(3,3,3) -> count=3;
//    raise ready -> pops in order 1,2,3, each carrying its own cycle's color.
//  4 Fill/overflow, DEPTH=16, ready=0: 8 cycles of 2 hits -> count=16, almostFull=1 from count>=12;
//    9th cycle of 2 hits -> both dropped, overflow=1 and sticky, count stays 16.
//  5 Full + simultaneous pop, count=16, ready=1, 2 hits -> lane0 accepted, lane1 dropped,
//    count=16, overflow=1; with count=15 instead -> both accepted, count=16, overflow stays 0.
//  6 Reset mid-operation: count=9, rst with 2 valid hits -> next cycle count=0, hitValid=0,
//    overflow=0; pointer wrap exercised by streaming 40 samples with random ready, order checked.

Source files
------------

// File: rtl/hit_sample_fifo.sv
// rtl/hit_sample_fifo.sv - multi-lane hit sample capture FIFO with show-ahead single-sample drain
// Lanes are packed into consecutive slots in ascending index order; lanes that do not fit are dropped.
module hit_sample_fifo #(
    parameter int SIGFIG       = 24,
    parameter int AXIS         = 3,
    parameter int COLORS       = 3,
    parameter int NUM_SAMPLES  = 2,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic signed [NUM_SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]              color_R18U,
    input  logic        [NUM_SAMPLES-1:0]                     hit_valid_R18H,
    output logic signed [AXIS-1:0][SIGFIG-1:0]                hit_R19S,
    output logic        [COLORS-1:0][SIGFIG-1:0]              color_R19U,
    output logic                                              hitValid_R19H,
    input  logic                                              hitReady_R19H,
    output logic        [$clog2(DEPTH+1)-1:0]                 count_RnnnnU,
    output logic                                              almostFull_RnnnnH,
    output logic                                              overflow_RnnnnH
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_THR  = CW'(DEPTH - AFULL_MARGIN);

    logic [AXIS-1:0][SIGFIG-1:0]   mem_hit   [DEPTH];
    logic [COLORS-1:0][SIGFIG-1:0] mem_color [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          afull;
    logic          ovf;

    logic                   pop;
    logic [CW-1:0]          space;
    logic [CW-1:0]          accepted;
    logic [CW-1:0]          count_next;
    logic                   drop;
    logic [NUM_SAMPLES-1:0] lane_we;
    logic [PW-1:0]          lane_addr [NUM_SAMPLES];

    assign pop   = (count != '0) && hitReady_R19H;
    // A same-cycle pop frees its slot for this cycle's push.
    assign space = DEPTH_C - count + CW'(pop);

    always_comb begin
        accepted = '0;
        drop     = 1'b0;
        lane_we  = '0;
        for (int l = 0; l < NUM_SAMPLES; l++) begin
            lane_addr[l] = wr_ptr + accepted[PW-1:0];
            if (hit_valid_R18H[l]) begin
                if (accepted < space) begin
                    lane_we[l] = 1'b1;
                    accepted   = accepted + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    assign count_next = count + accepted - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + accepted[PW-1:0];
            count  <= count_next;
            afull  <= (count_next >= AFULL_THR);
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; hits arriving during reset are simply not written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int l = 0; l < NUM_SAMPLES; l++) begin
                if (lane_we[l]) begin
                    mem_hit[lane_addr[l]]   <= hit_R18S[l];
                    mem_color[lane_addr[l]] <= color_R18U;
                end
            end
        end
    end

    assign hitValid_R19H     = (count != '0);
    assign hit_R19S          = hitValid_R19H ? mem_hit[rd_ptr]   : '0;
    assign color_R19U        = hitValid_R19H ? mem_color[rd_ptr] : '0;
    assign count_RnnnnU      = count;
    assign almostFull_RnnnnH = afull;
    assign overflow_RnnnnH   = ovf;
endmodule

// File: tb/tb_hit_sample_fifo.sv
// tb/tb_hit_sample_fifo.sv - directed self-checking bench for hit_sample_fifo
module tb_hit_sample_fifo;
    logic                           clk = 1'b0;
    logic                           rst;
    logic signed [1:0][2:0][23:0]   hit_in;
    logic        [2:0][23:0]        color_in;
    logic        [1:0]              hit_valid;
    logic signed [2:0][23:0]        hit_out;
    logic        [2:0][23:0]        color_out;
    logic                           valid_out;
    logic                           ready;
    logic        [4:0]              count;
    logic                           afull;
    logic                           ovf;

    int checks = 0;
    int errors = 0;
    int qh[$];
    int qc[$];

    hit_sample_fifo dut (
        .clk               (clk),
        .rst               (rst),
        .hit_R18S          (hit_in),
        .color_R18U        (color_in),
        .hit_valid_R18H    (hit_valid),
        .hit_R19S          (hit_out),
        .color_R19U        (color_out),
        .hitValid_R19H     (valid_out),
        .hitReady_R19H     (ready),
        .count_RnnnnU      (count),
        .almostFull_RnnnnH (afull),
        .overflow_RnnnnH   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] trip(input int a, input int b, input int c);
        trip = {24'(c), 24'(b), 24'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int a0, input int a1, input int col);
        hit_valid = v;
        hit_in[0] = trip(a0, a0, a0);
        hit_in[1] = trip(a1, a1, a1);
        color_in  = trip(col, col, col);
    endtask

    task automatic chk_head(input string tag, input int h, input int c);
        chk({tag, "_valid"}, 72'(valid_out), 72'(1));
        chk({tag, "_hit"}, hit_out, trip(h, h, h));
        chk({tag, "_color"}, color_out, trip(c, c, c));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int sent;
        int cyc;
        int n;
        logic [1:0] v;
        rst = 1'b1;
        ready = 1'b0;
        drive(2'b00, 0, 0, 0);

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 72'(valid_out), 72'(0));
        chk("rst_count", 72'(count), 72'(0));
        chk("rst_ovf", 72'(ovf), 72'(0));
        chk("rst_afull", 72'(afull), 72'(0));
        chk("rst_hit", hit_out, 72'(0));
        chk("rst_color", color_out, 72'(0));

        // 2: single push on lane 1 with ready high
        ready = 1'b1;
        hit_valid = 2'b10;
        hit_in[0] = trip(77, 77, 77);
        hit_in[1] = trip(5, 7, 9);
        color_in  = trip(1, 2, 3);
        tick();
        hit_valid = 2'b00;
        chk("single_valid", 72'(valid_out), 72'(1));
        chk("single_hit", hit_out, trip(5, 7, 9));
        chk("single_color", color_out, trip(1, 2, 3));
        chk("single_count", 72'(count), 72'(1));
        tick();
        chk("single_drain_count", 72'(count), 72'(0));
        chk("single_drain_valid", 72'(valid_out), 72'(0));
        chk("single_drain_hit", hit_out, 72'(0));

        // 3: ordering across cycles and lanes
        ready = 1'b0;
        drive(2'b11, 1, 2, 10);
        tick();
        drive(2'b01, 3, 99, 20);
        tick();
        drive(2'b00, 0, 0, 0);
        chk("order_count", 72'(count), 72'(3));
        chk_head("order_h1", 1, 10);
        ready = 1'b1;
        tick();
        chk_head("order_h2", 2, 10);
        chk("order_count2", 72'(count), 72'(2));
        tick();
        chk_head("order_h3", 3, 20);
        tick();
        chk("order_empty", 72'(valid_out), 72'(0));
        chk("order_count0", 72'(count), 72'(0));

        // 4: fill to 16 and overflow with ready low
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 2*i, 2*i + 1, i);
            tick();
            chk("fill_count", 72'(count), 72'(2*i + 2));
            chk("fill_afull", 72'(afull), 72'((2*i + 2) >= 12));
            chk("fill_ovf", 72'(ovf), 72'(0));
        end
        drive(2'b11, 90, 91, 9);
        tick();
        drive(2'b00, 0, 0, 0);
        chk("ovf_count", 72'(count), 72'(16));
        chk("ovf_set", 72'(ovf), 72'(1));
        chk("ovf_afull", 72'(afull), 72'(1));
        tick();
        chk("ovf_sticky", 72'(ovf), 72'(1));
        chk_head("ovf_head", 0, 0);

        // 5a: full with simultaneous pop
        ready = 1'b1;
        drive(2'b11, 100, 101, 7);
        tick();
        drive(2'b00, 0, 0, 0);
        ready = 1'b0;
        chk("fullpop_count", 72'(count), 72'(16));
        chk("fullpop_ovf", 72'(ovf), 72'(1));
        chk_head("fullpop_head", 1, 0);

        // 5b: count 15 plus pop accepts both lanes, then full plus pop drops lane 1
        do_reset();
        chk("r5_ovf", 72'(ovf), 72'(0));
        chk("r5_count", 72'(count), 72'(0));
        qh.delete();
        qc.delete();
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 2*i, 2*i + 1, 50 + i);
            qh.push_back(2*i);
            qc.push_back(50 + i);
            qh.push_back(2*i + 1);
            qc.push_back(50 + i);
            tick();
        end
        drive(2'b01, 14, 0, 57);
        qh.push_back(14);
        qc.push_back(57);
        tick();
        chk("c15_count", 72'(count), 72'(15));
        chk("c15_afull", 72'(afull), 72'(1));
        ready = 1'b1;
        drive(2'b11, 20, 21, 58);
        void'(qh.pop_front());
        void'(qc.pop_front());
        qh.push_back(20);
        qc.push_back(58);
        qh.push_back(21);
        qc.push_back(58);
        tick();
        chk("c15_push_count", 72'(count), 72'(16));
        chk("c15_push_ovf", 72'(ovf), 72'(0));
        drive(2'b11, 30, 31, 59);
        void'(qh.pop_front());
        void'(qc.pop_front());
        qh.push_back(30);
        qc.push_back(59);
        tick();
        drive(2'b00, 0, 0, 0);
        chk("c16_count", 72'(count), 72'(16));
        chk("c16_ovf", 72'(ovf), 72'(1));
        while (qh.size() != 0) begin
            chk_head("drain", qh[0], qc[0]);
            void'(qh.pop_front());
            void'(qc.pop_front());
            tick();
        end
        chk("drain_count", 72'(count), 72'(0));
        chk("drain_valid", 72'(valid_out), 72'(0));
        chk("drain_ovf", 72'(ovf), 72'(1));

        // 6: reset mid-operation with valid hits present
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, i, i, 0);
            tick();
        end
        drive(2'b01, 8, 0, 0);
        tick();
        chk("mid_count9", 72'(count), 72'(9));
        rst = 1'b1;
        drive(2'b11, 40, 41, 1);
        tick();
        rst = 1'b0;
        drive(2'b00, 0, 0, 0);
        chk("midrst_count", 72'(count), 72'(0));
        chk("midrst_valid", 72'(valid_out), 72'(0));
        chk("midrst_ovf", 72'(ovf), 72'(0));
        chk("midrst_afull", 72'(afull), 72'(0));
        tick();
        chk("midrst_idle_count", 72'(count), 72'(0));

        // 6b: stream 40 samples with random ready; pointers wrap repeatedly
        sent = 0;
        cyc = 0;
        qh.delete();
        qc.delete();
        while ((sent < 40 || qh.size() != 0) && cyc < 2000) begin
            ready = 1'($urandom_range(0, 1));
            chk("s_valid", 72'(valid_out), 72'(qh.size() != 0));
            chk("s_count", 72'(count), 72'(qh.size()));
            if (ready && qh.size() != 0) begin
                chk_head("s_head", qh[0], qc[0]);
                void'(qh.pop_front());
                void'(qc.pop_front());
            end
            v = 2'($urandom_range(0, 3));
            if (sent >= 40) v = 2'b00;
            if (sent == 39) v = v & 2'b01;
            n = int'(v[0]) + int'(v[1]);
            if (n > 16 - qh.size()) v = 2'b00;
            drive(v, 300 + sent, 300 + sent + int'(v[0]), 1000 + cyc);
            if (v[0]) begin
                qh.push_back(300 + sent);
                qc.push_back(1000 + cyc);
                sent++;
            end
            if (v[1]) begin
                qh.push_back(300 + sent);
                qc.push_back(1000 + cyc);
                sent++;
            end
            tick();
            cyc++;
        end
        drive(2'b00, 0, 0, 0);
        chk("s_bound", 72'(cyc < 2000), 72'(1));
        chk("s_final_count", 72'(count), 72'(0));
        chk("s_final_ovf", 72'(ovf), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
